workers_cpu_2_cpu_div_cell: RTL
===============================

WORKERS_CPU_2_CPU_DIV_CELL -- requirements
Module: workers_cpu_2_cpu_div_cell

Interface
REQ-001 The block SHALL use one clock and an asynchronous, active-high reset.
REQ-002 The block SHALL have no parameters; the datapath is fixed at 32 bits.
REQ-003 clk  in  1  rising-edge clock for all state.
REQ-004 reset  in  1  asynchronous, active-high reset.
REQ-005 E_src1  in  32  dividend, sampled only on an accepted start.
REQ-006 E_src2  in  32  divisor, sampled only on an accepted start.
REQ-007 div_start  in  1  single-cycle request to begin a divide.
REQ-008 div_signed  in  1  selects two's-complement (1) or unsigned (0) operands, sampled with start.
REQ-009 div_flush  in  1  synchronous abort of the operation in progress.
REQ-010 div_busy  out  1  high in every state other than IDLE.
REQ-011 div_done  out  1  single-cycle completion pulse.
REQ-012 div_quot  out  32  quotient register.
REQ-013 div_rem  out  32  remainder register.
REQ-014 div_by_zero  out  1  divisor-was-zero flag, valid with div_done.

Function
REQ-015 The FSM SHALL have the states IDLE, PREP, ITER, FIX and DONE.
REQ-016 Start acceptance: div_start is accepted only when the state is IDLE and div_flush=0; a start while busy SHALL be ignored without side effects.
REQ-017 On the accepting edge (edge k), the block SHALL latch the operands and div_signed, and the state SHALL go to PREP.
REQ-018 PREP (edge k+1):
- Form the absolute values when signed.
- Record the quotient sign (dividend sign XOR divisor sign) and the remainder sign (dividend sign).
- Record divisor==0.
- Clear the 6-bit iteration counter and the partial remainder.
- Go to ITER.
REQ-019 ITER SHALL perform one restoring radix-2 step per edge, 32 steps on edges k+2..k+33:
- Shift {remainder, dividend} left by 1.
- Trial-subtract the divisor using a 33-bit subtract.
- Keep the difference and set quotient bit 1 when it is non-negative; otherwise restore and set the bit 0.
REQ-020 After the 32nd step the state SHALL go to FIX.
REQ-021 FIX (edge k+34):
- Load div_quot and div_rem, applying sign correction when signed: negate the quotient if the quotient sign is 1, and negate the remainder if the remainder sign is 1.
- Go to DONE.
REQ-022 DONE SHALL assert div_done=1 for exactly one cycle, then return to IDLE on the next edge; div_quot, div_rem and div_by_zero SHALL hold until the next accepted start's FIX.
REQ-023 Total latency SHALL be fixed: div_done is high in the cycle following edge k+34, for every operand value including divide-by-zero.
REQ-024 Signed semantics: the quotient truncates toward zero, and a non-zero remainder takes the sign of the dividend.
REQ-025 Divide by zero: div_quot=0xFFFFFFFF, div_rem=the original E_src1 value (no sign correction), and div_by_zero=1; div_by_zero SHALL be 0 for any non-zero divisor.
REQ-026 Signed overflow 0x80000000 / 0xFFFFFFFF SHALL yield div_quot=0x80000000 and div_rem=0 with no flag.
REQ-027 div_flush=1 in any non-IDLE state SHALL force IDLE on the next edge with no div_done; the result registers SHALL keep their prior values.
REQ-028 When div_flush and div_start are high in the same cycle, flush SHALL win and the start SHALL be dropped.
REQ-029 div_flush while IDLE SHALL have no effect.
REQ-030 div_done and div_busy SHALL never be driven from combinational paths of the inputs.

Reset
REQ-031 While reset=1, the state SHALL be IDLE and every output SHALL be 0, independent of clk: div_busy=0, div_done=0, div_by_zero=0, div_quot=0x00000000, div_rem=0x00000000.
REQ-032 Asserting reset mid-operation SHALL abandon the operation with no div_done after release.
REQ-033 The first start after reset release SHALL be accepted on the first edge at which div_start=1.

Verification
REQ-034 Unsigned: E_src1=100, E_src2=7, div_signed=0 -> div_done at edge k+34+1 cycle; quot=0x0000000E, rem=0x00000002, div_by_zero=0, div_busy high for exactly 35 cycles.
REQ-035 Signed: E_src1=0xFFFFFFF9 (-7), E_src2=2 -> quot=0xFFFFFFFD, rem=0xFFFFFFFF; and 7 / 0xFFFFFFFE (-2) -> quot=0xFFFFFFFD, rem=0x00000001.
REQ-036 Divide by zero: E_src1=0x12345678, E_src2=0, in both signed and unsigned modes -> quot=0xFFFFFFFF, rem=0x12345678, div_by_zero=1, with the same latency as REQ-034.
REQ-037 Overflow: 0x80000000 / 0xFFFFFFFF signed -> quot=0x80000000, rem=0, div_by_zero=0; the same operands unsigned -> quot=0x00000000, rem=0x80000000.
REQ-038 Control: div_start pulsed during ITER -> ignored, and the first result is unchanged. div_flush at the 10th ITER cycle -> div_busy=0 next cycle, no div_done, outputs keep the previous result. A following start of 100/7 -> 14 rem 2.
REQ-039 Reset: reset asserted during ITER -> all outputs 0 immediately; after release no div_done until a new start; then 0xFFFFFFFF/0x10 unsigned -> quot=0x0FFFFFFF, rem=0xF.

Source files
------------

// File: rtl/workers_cpu_2_cpu_div_cell.sv
// workers_cpu_2_cpu_div_cell: fixed-latency 32-bit signed/unsigned restoring divider
module workers_cpu_2_cpu_div_cell (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] E_src1,
  input  logic [31:0] E_src2,
  input  logic        div_start,
  input  logic        div_signed,
  input  logic        div_flush,
  output logic        div_busy,
  output logic        div_done,
  output logic [31:0] div_quot,
  output logic [31:0] div_rem,
  output logic        div_by_zero
);
  typedef enum logic [2:0] {IDLE, PREP, ITER, FIX, DONE} state_t;
  state_t state, state_nx;
  logic [31:0] op_a, op_b, q, r;
  logic        sgn, q_neg, r_neg, dz;
  logic [5:0]  cnt;
  logic [32:0] sh, diff;
  assign sh   = {r, q[31]};
  assign diff = sh - {1'b0, op_b};
  assign div_busy = state != IDLE;
  assign div_done = state == DONE;
  always_comb begin
    state_nx = state;
    if (state == IDLE) state_nx = (div_start && !div_flush) ? PREP : IDLE;
    else if (div_flush) state_nx = IDLE;
    else if (state == PREP) state_nx = ITER;
    else if (state == ITER) state_nx = (cnt == 6'd31) ? FIX : ITER;
    else if (state == FIX) state_nx = DONE;
    else state_nx = IDLE;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else state <= state_nx;
  end
  // op_a keeps the raw dividend for the divide-by-zero remainder; op_b becomes |divisor|
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      op_a <= '0;
      op_b <= '0;
      q <= '0;
      r <= '0;
      sgn <= 1'b0;
      q_neg <= 1'b0;
      r_neg <= 1'b0;
      dz <= 1'b0;
      cnt <= '0;
      div_quot <= '0;
      div_rem <= '0;
      div_by_zero <= 1'b0;
    end else if (state == IDLE) begin
      if (div_start && !div_flush) begin
        op_a <= E_src1;
        op_b <= E_src2;
        sgn <= div_signed;
      end
    end else if (state == PREP) begin
      q <= (sgn && op_a[31]) ? -op_a : op_a;
      op_b <= (sgn && op_b[31]) ? -op_b : op_b;
      q_neg <= sgn && (op_a[31] ^ op_b[31]);
      r_neg <= sgn && op_a[31];
      dz <= op_b == '0;
      cnt <= '0;
      r <= '0;
    end else if (state == ITER) begin
      r <= diff[32] ? sh[31:0] : diff[31:0];
      q <= {q[30:0], ~diff[32]};
      cnt <= cnt + 6'd1;
    end else if (state == FIX && !div_flush) begin
      div_quot <= dz ? 32'hFFFF_FFFF : (q_neg ? -q : q);
      div_rem <= dz ? op_a : (r_neg ? -r : r);
      div_by_zero <= dz;
    end
  end
endmodule
